// File: rtl/lc3_memaccess_ctrl.sv
// LC3 MemAccess stage sequencer: one handshaked memory instruction at a time,
// covering direct, indirect and store accesses with a configurable memory latency.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | ready, waiting for start (mem_state=3)
// S_IND   | reading indirect pointer at latched ea (mem_state=1)
// S_READ  | reading data word, latched into memout on last cycle (0)
// S_WRITE | writing latched store data, DMem_we high (mem_state=2)
// S_FIN   | one-cycle completion, done (and err if illegal) (3)
module lc3_memaccess_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic [15:0] ea,
  input  logic [15:0] st_data,
  input  logic [15:0] DMem_dout,
  output logic        ready,
  output logic [1:0]  mem_state,
  output logic        M_control,
  output logic [15:0] DMem_addr,
  output logic [15:0] DMem_din,
  output logic        DMem_we,
  output logic [15:0] memout,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {S_IDLE, S_IND, S_READ, S_WRITE, S_FIN} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_STI = 4'b1011;

  localparam logic [1:0] MS_READ  = 2'd0;
  localparam logic [1:0] MS_IND   = 2'd1;
  localparam logic [1:0] MS_WRITE = 2'd2;
  localparam logic [1:0] MS_IDLE  = 2'd3;

  state_t      state;
  logic [3:0]  cnt;
  logic        is_st;
  logic [15:0] st_q;

  assign ready = (state == S_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      is_st     <= 1'b0;
      st_q      <= '0;
      mem_state <= MS_IDLE;
      M_control <= 1'b0;
      DMem_addr <= '0;
      DMem_din  <= '0;
      DMem_we   <= 1'b0;
      memout    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            st_q      <= st_data;
            is_st     <= opcode[0];
            cnt       <= CNT_INIT;
            M_control <= 1'b0;
            case (opcode)
              OP_LD, OP_LDR: begin
                state     <= S_READ;
                mem_state <= MS_READ;
                DMem_addr <= ea;
              end
              OP_ST, OP_STR: begin
                state     <= S_WRITE;
                mem_state <= MS_WRITE;
                DMem_addr <= ea;
                DMem_din  <= st_data;
                DMem_we   <= 1'b1;
              end
              OP_LDI, OP_STI: begin
                state     <= S_IND;
                mem_state <= MS_IND;
                DMem_addr <= ea;
              end
              default: begin
                // illegal opcode: no memory access, address bus left untouched
                state <= S_FIN;
                done  <= 1'b1;
                err   <= 1'b1;
              end
            endcase
          end
        end
        S_IND: begin
          if (cnt == 4'd0) begin
            cnt       <= CNT_INIT;
            DMem_addr <= DMem_dout;
            M_control <= 1'b1;
            if (is_st) begin
              state     <= S_WRITE;
              mem_state <= MS_WRITE;
              DMem_din  <= st_q;
              DMem_we   <= 1'b1;
            end else begin
              state     <= S_READ;
              mem_state <= MS_READ;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_READ: begin
          if (cnt == 4'd0) begin
            memout    <= DMem_dout;
            state     <= S_FIN;
            mem_state <= MS_IDLE;
            M_control <= 1'b0;
            done      <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_WRITE: begin
          if (cnt == 4'd0) begin
            DMem_we   <= 1'b0;
            state     <= S_FIN;
            mem_state <= MS_IDLE;
            M_control <= 1'b0;
            done      <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_memaccess_ctrl.sv
module tb_lc3_memaccess_ctrl;

   int n_cmp = 0;
   int n_err = 0;

   logic        clock = 1'b0;
   logic        rst_n;
   logic [3:0]  opcode;
   logic [15:0] ea, st_data;
   logic        s1, s2, s3;
   logic        pl_en;
   logic [15:0] pl_addr, pl_data;

   always #5 clock = ~clock;

   logic        rdy1, mc1, we1, done1, err1;
   logic [1:0]  ms1;
   logic [15:0] addr1, din1, dout1, mo1;
   logic        rdy2, mc2, we2, done2, err2;
   logic [1:0]  ms2;
   logic [15:0] addr2, din2, dout2, mo2;
   logic        rdy3, mc3, we3, done3, err3;
   logic [1:0]  ms3;
   logic [15:0] addr3, din3, dout3, mo3;

   logic [15:0] m1 [0:65535];
   logic [15:0] m2 [0:65535];
   logic [15:0] m3 [0:65535];

   always @(posedge clock) begin
      if (pl_en) begin
         m1[pl_addr] <= pl_data;
         m2[pl_addr] <= pl_data;
         m3[pl_addr] <= pl_data;
      end
      if (we1) m1[addr1] <= din1;
      if (we2) m2[addr2] <= din2;
      if (we3) m3[addr3] <= din3;
   end

   assign dout1 = m1[addr1];
   assign dout2 = m2[addr2];
   assign dout3 = m3[addr3];

   lc3_memaccess_ctrl #(.MEM_LAT(1)) d1 (
      .clock(clock), .reset(rst_n), .start(s1), .opcode(opcode), .ea(ea),
      .st_data(st_data), .DMem_dout(dout1), .ready(rdy1), .mem_state(ms1),
      .M_control(mc1), .DMem_addr(addr1), .DMem_din(din1), .DMem_we(we1),
      .memout(mo1), .done(done1), .err(err1));

   lc3_memaccess_ctrl #(.MEM_LAT(2)) d2 (
      .clock(clock), .reset(rst_n), .start(s2), .opcode(opcode), .ea(ea),
      .st_data(st_data), .DMem_dout(dout2), .ready(rdy2), .mem_state(ms2),
      .M_control(mc2), .DMem_addr(addr2), .DMem_din(din2), .DMem_we(we2),
      .memout(mo2), .done(done2), .err(err2));

   lc3_memaccess_ctrl #(.MEM_LAT(3)) d3 (
      .clock(clock), .reset(rst_n), .start(s3), .opcode(opcode), .ea(ea),
      .st_data(st_data), .DMem_dout(dout3), .ready(rdy3), .mem_state(ms3),
      .M_control(mc3), .DMem_addr(addr3), .DMem_din(din3), .DMem_we(we3),
      .memout(mo3), .done(done3), .err(err3));

   task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
      n_cmp++;
      if (o !== e) begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      pl_addr = a;
      pl_data = d;
      pl_en   = 1'b1;
      step();
      pl_en   = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
      opcode = 4'h0; ea = 16'h0; st_data = 16'h0;
      pl_en = 1'b0; pl_addr = 16'h0; pl_data = 16'h0;

      #22;
      chk("rst_mem_state", ms1, 2'd3);
      chk("rst_m_control", mc1, 1'b0);
      chk("rst_we", we1, 1'b0);
      chk("rst_addr", addr1, 16'h0000);
      chk("rst_din", din1, 16'h0000);
      chk("rst_memout", mo1, 16'h0000);
      chk("rst_done", done1, 1'b0);
      chk("rst_err", err1, 1'b0);
      step();
      rst_n = 1'b1;
      step();
      chk("rst_ready", rdy1, 1'b1);

      preload(16'h3000, 16'hBEEF);
      preload(16'h3001, 16'h4000);

      opcode = 4'b0010; ea = 16'h3000; s1 = 1'b1;
      chk("ld_ms_before", ms1, 2'd3);
      step();
      s1 = 1'b0; ea = 16'hFFFF;
      chk("ld_ms_read", ms1, 2'd0);
      chk("ld_addr", addr1, 16'h3000);
      chk("ld_ready_busy", rdy1, 1'b0);
      chk("ld_done_early", done1, 1'b0);
      step();
      chk("ld_ms_fin", ms1, 2'd3);
      chk("ld_done", done1, 1'b1);
      chk("ld_memout", mo1, 16'hBEEF);
      chk("ld_err", err1, 1'b0);
      step();
      chk("ld_done_clear", done1, 1'b0);
      chk("ld_ready_back", rdy1, 1'b1);

      opcode = 4'b1011; ea = 16'h3001; st_data = 16'h1234; s3 = 1'b1;
      step();
      s3 = 1'b0; ea = 16'h0000; st_data = 16'hAAAA;
      for (int i = 0; i < 3; i++) begin
         chk("sti_ms_ind", ms3, 2'd1);
         chk("sti_mc_ind", mc3, 1'b0);
         chk("sti_addr_ind", addr3, 16'h3001);
         chk("sti_we_ind", we3, 1'b0);
         step();
      end
      for (int i = 0; i < 3; i++) begin
         chk("sti_ms_wr", ms3, 2'd2);
         chk("sti_mc_wr", mc3, 1'b1);
         chk("sti_addr_wr", addr3, 16'h4000);
         chk("sti_we_wr", we3, 1'b1);
         chk("sti_din", din3, 16'h1234);
         chk("sti_done_early", done3, 1'b0);
         step();
      end
      chk("sti_done", done3, 1'b1);
      chk("sti_ms_fin", ms3, 2'd3);
      chk("sti_we_fin", we3, 1'b0);
      chk("sti_mc_fin", mc3, 1'b0);
      chk("sti_memout", mo3, 16'h0000);
      chk("sti_mem", m3[16'h4000], 16'h1234);

      opcode = 4'b0001; ea = 16'h3000; s1 = 1'b1;
      step();
      s1 = 1'b0;
      chk("ill_done", done1, 1'b1);
      chk("ill_err", err1, 1'b1);
      chk("ill_we", we1, 1'b0);
      chk("ill_ms", ms1, 2'd3);
      chk("ill_ready", rdy1, 1'b0);
      chk("ill_memout", mo1, 16'hBEEF);
      opcode = 4'b0010; s1 = 1'b1;
      step();
      s1 = 1'b0;
      chk("busy_done", done1, 1'b0);
      chk("busy_err", err1, 1'b0);
      chk("busy_ready", rdy1, 1'b1);
      chk("busy_ms", ms1, 2'd3);

      opcode = 4'b1010; ea = 16'h3001; s2 = 1'b1;
      step();
      s2 = 1'b0;
      chk("abort_ms_ind1", ms2, 2'd1);
      step();
      chk("abort_ms_ind2", ms2, 2'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_ms", ms2, 2'd3);
      chk("abort_addr", addr2, 16'h0000);
      chk("abort_mc", mc2, 1'b0);
      chk("abort_we", we2, 1'b0);
      chk("abort_done", done2, 1'b0);
      chk("abort_memout", mo2, 16'h0000);
      chk("abort_ready", rdy2, 1'b1);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("abort_no_done", done2, 1'b0);
      end
      opcode = 4'b0010; ea = 16'h3000; s2 = 1'b1;
      step();
      s2 = 1'b0;
      chk("post_ms_rd1", ms2, 2'd0);
      chk("post_addr", addr2, 16'h3000);
      step();
      chk("post_ms_rd2", ms2, 2'd0);
      chk("post_done_early", done2, 1'b0);
      step();
      chk("post_done", done2, 1'b1);
      chk("post_memout", mo2, 16'hBEEF);

      opcode = 4'b0011; ea = 16'h3005; st_data = 16'h00FF; s1 = 1'b1;
      step();
      opcode = 4'b0010;
      chk("b2b_ms_wr", ms1, 2'd2);
      chk("b2b_we", we1, 1'b1);
      chk("b2b_addr_wr", addr1, 16'h3005);
      chk("b2b_ready_wr", rdy1, 1'b0);
      step();
      chk("b2b_st_done", done1, 1'b1);
      chk("b2b_ready_fin", rdy1, 1'b0);
      chk("b2b_we_fin", we1, 1'b0);
      step();
      chk("b2b_ready_idle", rdy1, 1'b1);
      chk("b2b_ms_idle", ms1, 2'd3);
      chk("b2b_mem", m1[16'h3005], 16'h00FF);
      step();
      s1 = 1'b0;
      chk("b2b_ms_rd", ms1, 2'd0);
      chk("b2b_addr_rd", addr1, 16'h3005);
      step();
      chk("b2b_ld_done", done1, 1'b1);
      chk("b2b_memout", mo1, 16'h00FF);
      step();
      chk("b2b_final_ready", rdy1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
